// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter feeding 1-4 byte words, MSB first, to a UART transmitter
module uart_tx_arbiter #(
  parameter int TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic [1:0]  len0,
  input  logic [1:0]  len1,
  output logic        ack0,
  output logic        ack1,
  output logic [7:0]  tx_byte,
  output logic        tx_start,
  input  logic        tx_done,
  output logic        busy,
  output logic        grant,
  output logic        err_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_ACK} state_t;

  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_shift;
  logic [1:0]  r_len;
  logic [1:0]  r_cnt;
  logic [19:0] r_tmo;
  logic        r_grant;
  logic        r_last;
  logic        r_err;
  logic [7:0]  r_byte;
  logic        w_any;
  logic        w_win;
  logic        w_last_byte;
  logic        w_tmo_hit;

  assign w_any       = req0 | req1;
  // On a tie the requester not served last wins; a lone request always wins.
  assign w_win       = (req0 & req1) ? ~r_last : req1;
  assign w_last_byte = (r_cnt == r_len);
  assign w_tmo_hit   = (r_tmo == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any) w_next = S_START;
      end
      S_START: w_next = S_WAIT;
      S_WAIT: begin
        // tx_done takes priority over the timeout terminal count
        if (tx_done) w_next = w_last_byte ? S_ACK : S_START;
        else if (w_tmo_hit) w_next = S_ACK;
      end
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_tmo   <= '0;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
      r_err   <= 1'b0;
      r_byte  <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_win;
            r_shift <= w_win ? data1 : data0;
            r_len   <= w_win ? len1 : len0;
            r_cnt   <= '0;
            r_tmo   <= '0;
            r_err   <= 1'b0;
          end
        end
        S_START: r_byte <= r_shift[31:24];
        S_WAIT: begin
          if (tx_done) begin
            if (!w_last_byte) begin
              r_shift <= {r_shift[23:0], 8'h00};
              r_cnt   <= r_cnt + 2'd1;
              r_tmo   <= '0;
            end
          end else begin
            r_tmo <= r_tmo + 20'd1;
            if (w_tmo_hit) r_err <= 1'b1;
          end
        end
        S_ACK:   r_last <= r_grant;
        default: ;
      endcase
    end
  end

  assign tx_start    = (r_state == S_START);
  assign tx_byte     = tx_start ? r_shift[31:24] : r_byte;
  assign busy        = (r_state != S_IDLE);
  assign ack0        = (r_state == S_ACK) & ~r_grant;
  assign ack1        = (r_state == S_ACK) & r_grant;
  assign grant       = r_grant;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - vector table, corner sequences and randomized model comparison for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int TMO_M = 20;
  localparam int TMO_S = 8;

  typedef struct packed {
    int          nbytes;
    logic [31:0] bytes;
    logic        a0;
    logic        a1;
    logic        err;
    logic        grant;
    logic        err_start;
    logic        gap_ok;
    logic        hung;
    logic        idle_busy;
    logic        idle_ack;
    logic        idle_err;
    logic [7:0]  hold;
    int          lat_start;
    int          lat_ack;
  } obs_t;

  typedef struct {
    logic        r0;
    logic        r1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  l0;
    logic [1:0]  l1;
    int          dly;
    logic        spur;
    logic        eg;
    int          en;
    logic [31:0] eb;
    logic        ee;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, tx_done, sel;
  logic [31:0] data0, data1;
  logic [1:0]  len0, len1;
  logic        m_ack0, m_ack1, m_tx_start, m_busy, m_grant, m_err;
  logic        t_ack0, t_ack1, t_tx_start, t_busy, t_grant, t_err;
  logic [7:0]  m_tx_byte, t_tx_byte;
  logic        w_ack0, w_ack1, w_tx_start, w_busy, w_grant, w_err;
  logic [7:0]  w_tx_byte;
  int          checks = 0;
  int          failures = 0;
  int          g_dly [4];
  logic        m_last;
  vec_t        vecs [8];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.TIMEOUT(TMO_M)) u_dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .len0(len0), .len1(len1), .ack0(m_ack0), .ack1(m_ack1), .tx_byte(m_tx_byte),
    .tx_start(m_tx_start), .tx_done(tx_done), .busy(m_busy), .grant(m_grant),
    .err_timeout(m_err)
  );

  uart_tx_arbiter #(.TIMEOUT(TMO_S)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .len0(len0), .len1(len1), .ack0(t_ack0), .ack1(t_ack1), .tx_byte(t_tx_byte),
    .tx_start(t_tx_start), .tx_done(tx_done), .busy(t_busy), .grant(t_grant),
    .err_timeout(t_err)
  );

  assign w_ack0     = sel ? t_ack0     : m_ack0;
  assign w_ack1     = sel ? t_ack1     : m_ack1;
  assign w_tx_start = sel ? t_tx_start : m_tx_start;
  assign w_tx_byte  = sel ? t_tx_byte  : m_tx_byte;
  assign w_busy     = sel ? t_busy     : m_busy;
  assign w_grant    = sel ? t_grant    : m_grant;
  assign w_err      = sel ? t_err      : m_err;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    tx_done = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    m_last = 1'b1;
    step();
  endtask

  // Reactive transmitter: answers byte k in WAIT cycle g_dly[k], records what the DUT did.
  task automatic txn(input logic r0, input logic r1, input logic [31:0] d0, input logic [31:0] d1,
                     input logic [1:0] l0, input logic [1:0] l1, input logic spur, output obs_t o);
    int cnt;
    int last_start;
    o = '0;
    o.hung = 1'b1;
    o.gap_ok = 1'b1;
    req0 = r0; req1 = r1; data0 = d0; data1 = d1; len0 = l0; len1 = l1;
    tx_done = spur;
    cnt = 0;
    last_start = 0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      step();
      tx_done = 1'b0;
      if (w_ack0 || w_ack1) begin
        o.a0 = w_ack0; o.a1 = w_ack1; o.err = w_err; o.grant = w_grant;
        o.lat_ack = cyc - last_start;
        o.hung = 1'b0;
        if (w_ack0) req0 = 1'b0;
        if (w_ack1) req1 = 1'b0;
        break;
      end
      if (w_tx_start) begin
        if (o.nbytes == 0) begin
          o.lat_start = cyc;
          o.err_start = w_err;
        end else if (cyc - last_start != g_dly[(o.nbytes - 1) & 3] + 1) begin
          o.gap_ok = 1'b0;
        end
        o.bytes = {o.bytes[23:0], w_tx_byte};
        cnt = g_dly[o.nbytes & 3];
        o.nbytes++;
        last_start = cyc;
        data0 = $urandom; data1 = $urandom;
        len0 = 2'($urandom); len1 = 2'($urandom);
        tx_done = spur;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) tx_done = 1'b1;
      end
    end
    if (!o.hung) begin
      step();
      o.idle_busy = w_busy;
      o.idle_ack = w_ack0 | w_ack1;
      o.idle_err = w_err;
      o.hold = w_tx_byte;
    end
  endtask

  task automatic cmp(input string tag, input obs_t o, input logic eg, input int en,
                     input logic [31:0] eb, input logic ee, input int tmo);
    int exp_lat;
    exp_lat = ee ? tmo + 1 : g_dly[(en - 1) & 3] + 1;
    chk({tag, ".hung"}, 32'(o.hung), 32'd0);
    chk({tag, ".grant"}, 32'(o.grant), 32'(eg));
    chk({tag, ".nbytes"}, o.nbytes, en);
    chk({tag, ".bytes"}, o.bytes, eb);
    chk({tag, ".err"}, 32'(o.err), 32'(ee));
    chk({tag, ".ack0"}, 32'(o.a0), 32'(!eg));
    chk({tag, ".ack1"}, 32'(o.a1), 32'(eg));
    chk({tag, ".lat_start"}, o.lat_start, 32'd1);
    chk({tag, ".lat_ack"}, o.lat_ack, exp_lat);
    chk({tag, ".gap"}, 32'(o.gap_ok), 32'd1);
    chk({tag, ".idle_busy"}, 32'(o.idle_busy), 32'd0);
    chk({tag, ".idle_ack"}, 32'(o.idle_ack), 32'd0);
    chk({tag, ".hold"}, 32'(o.hold), 32'(eb[7:0]));
  endtask

  initial begin
    obs_t        o;
    logic        rr0, rr1, rw, re, rspur;
    logic [31:0] rd0, rd1, rd, reb;
    logic [1:0]  rl0, rl1, rl;
    int          rn, rv;

    // fields: r0 r1 d0 d1 l0 l1 dly spur | grant nbytes bytes err
    vecs[0] = '{1'b1, 1'b0, 32'hA1B2C3D4, 32'h0, 2'd3, 2'd0, 10, 1'b0, 1'b0, 4, 32'hA1B2C3D4, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h0, 32'h5A000000, 2'd0, 2'd0, 10, 1'b0, 1'b1, 1, 32'h5A, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h10203040, 32'h50607080, 2'd1, 2'd2, 3, 1'b0, 1'b0, 2, 32'h1020, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'h10203040, 32'h50607080, 2'd1, 2'd2, 3, 1'b1, 1'b1, 3, 32'h506070, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 32'h10203040, 32'h50607080, 2'd1, 2'd2, 1, 1'b0, 1'b0, 2, 32'h1020, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 32'h10203040, 32'h50607080, 2'd1, 2'd2, 1, 1'b1, 1'b1, 3, 32'h506070, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 32'h11223344, 32'h0, 2'd1, 2'd0, TMO_M, 1'b1, 1'b0, 2, 32'h1122, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 32'h0, 32'hDEADBEEF, 2'd0, 2'd3, TMO_M + 1, 1'b1, 1'b1, 1, 32'hDE, 1'b1};

    sel = 1'b0; rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; tx_done = 1'b0;
    data0 = '0; data1 = '0; len0 = '0; len1 = '0; m_last = 1'b1;
    step();
    step();
    chk("rst.busy", 32'(m_busy), 32'd0);
    chk("rst.tx_start", 32'(m_tx_start), 32'd0);
    chk("rst.acks", {30'd0, m_ack1, m_ack0}, 32'd0);
    chk("rst.tx_byte", 32'(m_tx_byte), 32'h00);
    chk("rst.grant", 32'(m_grant), 32'd0);
    chk("rst.err", 32'(m_err), 32'd0);
    chk("rst8.busy", 32'(t_busy), 32'd0);
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 4; i++) g_dly[i] = vecs[v].dly;
      txn(vecs[v].r0, vecs[v].r1, vecs[v].d0, vecs[v].d1, vecs[v].l0, vecs[v].l1, vecs[v].spur, o);
      cmp($sformatf("vec%0d", v), o, vecs[v].eg, vecs[v].en, vecs[v].eb, vecs[v].ee, TMO_M);
    end

    // Reset during WAIT of byte 2: immediate clear, no ack, restart from byte 1.
    do_reset();
    req0 = 1'b1; req1 = 1'b0; data0 = 32'hCAFEF00D; len0 = 2'd3;
    step();
    chk("mid.start1", {23'd0, m_tx_start, m_tx_byte}, {23'd0, 1'b1, 8'hCA});
    step();
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("mid.start2", {23'd0, m_tx_start, m_tx_byte}, {23'd0, 1'b1, 8'hFE});
    step();
    chk("mid.wait_busy", 32'(m_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid.rst_busy", 32'(m_busy), 32'd0);
    chk("mid.rst_byte", 32'(m_tx_byte), 32'h00);
    chk("mid.rst_grant_err", {30'd0, m_grant, m_err}, 32'd0);
    chk("mid.rst_acks", {30'd0, m_ack1, m_ack0}, 32'd0);
    req0 = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("mid.quiet%0d", k), {29'd0, m_busy, m_ack1, m_ack0}, 32'd0);
    end
    for (int i = 0; i < 4; i++) g_dly[i] = 2;
    txn(1'b1, 1'b1, 32'hCAFEF00D, 32'h99999999, 2'd3, 2'd3, 1'b0, o);
    cmp("mid.restart", o, 1'b0, 4, 32'hCAFEF00D, 1'b0, TMO_M);

    // Timeout with TIMEOUT=8: remaining bytes dropped, error held until next grant.
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) g_dly[i] = 100;
    txn(1'b1, 1'b0, 32'h01020304, 32'h0, 2'd3, 2'd0, 1'b0, o);
    cmp("to8", o, 1'b0, 1, 32'h01, 1'b1, TMO_S);
    chk("to8.idle_err", 32'(o.idle_err), 32'd1);
    for (int i = 0; i < 4; i++) g_dly[i] = TMO_S;
    txn(1'b0, 1'b1, 32'h0, 32'h77880000, 2'd0, 2'd1, 1'b1, o);
    cmp("to8.next", o, 1'b1, 2, 32'h7788, 1'b0, TMO_S);
    chk("to8.err_cleared", 32'(o.err_start), 32'd0);

    // Randomized transfers against the transaction-level model.
    sel = 1'b0;
    do_reset();
    for (int it = 0; it < 150; it++) begin
      rv = $urandom_range(1, 3);
      rr0 = rv[0]; rr1 = rv[1];
      rd0 = $urandom; rd1 = $urandom;
      rl0 = 2'($urandom); rl1 = 2'($urandom);
      rspur = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++)
        g_dly[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TMO_M + 1, TMO_M + 3))
                                               : int'($urandom_range(1, TMO_M));
      txn(rr0, rr1, rd0, rd1, rl0, rl1, rspur, o);
      rw = (rr0 && rr1) ? ~m_last : rr1;
      rd = rw ? rd1 : rd0;
      rl = rw ? rl1 : rl0;
      rn = int'(rl) + 1;
      re = 1'b0;
      for (int i = 0; i <= int'(rl); i++) begin
        if (g_dly[i] > TMO_M) begin
          rn = i + 1;
          re = 1'b1;
          break;
        end
      end
      reb = rd >> (8 * (4 - rn));
      cmp($sformatf("rnd%0d", it), o, rw, rn, reb, re, TMO_M);
      m_last = rw;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 50000, giving the maximum number of clk cycles to wait for tx_done per byte (range 2..2^20-1).
REQ-002 SHALL have port clk  in  1  single system clock, all logic on its rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0/req1  in  1  transfer request, one per requester, held high until the matching ack.
REQ-005 SHALL have ports data0/data1  in  32  word to send, MSB byte first.
REQ-006 SHALL have ports len0/len1  in  2  byte count minus one (0 = 1 byte, 3 = 4 bytes).
REQ-007 SHALL have ports ack0/ack1  out  1  one-cycle pulse marking completion of that requester's transfer.
REQ-008 SHALL have port tx_byte  out  8  byte presented to the UART transmitter.
REQ-009 SHALL have port tx_start  out  1  one-cycle pulse requesting transmission of tx_byte.
REQ-010 SHALL have port tx_done  in  1  one-cycle pulse from the transmitter when a byte has finished.
REQ-011 SHALL have port busy  out  1  high in every state except IDLE.
REQ-012 SHALL have port grant  out  1  index of the requester owning the current transfer.
REQ-013 SHALL have port err_timeout  out  1  high when the last transfer ended on a timeout.

Function
REQ-014 SHALL implement the states IDLE, START, WAIT, ACK.
REQ-015 In IDLE with any req high, SHALL latch the granted requester's data and len into a 32-bit shift register and 2-bit length register, clear the byte counter and timeout counter, update grant, and move to START on the next edge.
REQ-016 SHALL arbitrate round-robin: if only one req is high, that requester wins; if both are high, the requester not granted last wins; last-granted resets to 1, so req0 wins the first tie.
REQ-017 SHALL sample req/data/len only in IDLE; changes while busy are ignored.
REQ-018 In START, SHALL drive tx_byte = shift[31:24] and tx_start = 1 for exactly one cycle, then go to WAIT.
REQ-019 tx_byte SHALL hold its last value outside START; it is 8'h00 after reset.
REQ-020 In WAIT, SHALL increment the timeout counter each cycle that tx_done = 0.
REQ-021 On tx_done in WAIT with byte counter = len, SHALL go to ACK with err_timeout = 0.
REQ-022 On tx_done in WAIT with byte counter < len, SHALL shift left by 8, increment the byte counter, clear the timeout counter and return to START; bytes therefore go out MSB first with no gap beyond one START cycle.
REQ-023 When the timeout counter reaches TIMEOUT-1 with no tx_done, SHALL set err_timeout = 1 and go to ACK, abandoning the remaining bytes.
REQ-024 If tx_done and the timeout terminal count occur in the same cycle, tx_done SHALL win (no error).
REQ-025 SHALL ignore tx_done outside WAIT.
REQ-026 In ACK, SHALL pulse ack[grant] for one cycle, record grant as last-granted, and return to IDLE.
REQ-027 err_timeout SHALL hold until the next grant in IDLE clears it.
REQ-028 A requester whose req is still high in the IDLE cycle after ACK SHALL be treated as a new request, subject to round-robin.
REQ-029 Minimum latency SHALL be: req sampled at edge N -> tx_start high in cycle N+1; last tx_done at edge M -> ack high in cycle M+1.

Reset
REQ-030 rst_n low SHALL immediately force IDLE and clear outputs and registers: busy = 0, tx_start = 0, ack0 = ack1 = 0, tx_byte = 8'h00, grant = 0, err_timeout = 0, last-granted = 1, counters = 0.
REQ-031 Reset asserted mid-transfer SHALL abort it without an ack pulse; after release, the arbiter resumes from IDLE.

Verification
REQ-032 req0 only, data0 = 32'hA1B2C3D4, len0 = 3, tx_done 10 cycles after each tx_start -> tx_byte sequence A1, B2, C3, D4, four tx_start pulses, one ack0, err_timeout = 0.
REQ-033 req1 with len1 = 0, data1 = 32'h5A000000 -> single tx_start with tx_byte = 5A, then ack1; no further tx_start.
REQ-034 req0 and req1 high together from reset, each re-raised after its ack -> grants alternate 0, 1, 0, 1, with ack0/ack1 alternating.
REQ-035 TIMEOUT = 8, tx_done never returned -> ack pulses after the timeout, err_timeout = 1, rest of the word dropped; the next grant clears err_timeout.
REQ-036 rst_n pulsed low during WAIT of byte 2 -> outputs reset immediately, no ack; a new req0 after release restarts from byte 1.
REQ-037 Spurious tx_done in IDLE and START, plus tx_done in the same cycle as the timeout terminal count -> stray pulses ignored, transfer completes without error.
